// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared op codes, JEDEC command bytes and sequencer state types
package flash_pkg;

   // Operation encodings on the Op input; 5..7 are illegal
   localparam logic [2:0] OP_READ         = 3'd0;
   localparam logic [2:0] OP_PROGRAM      = 3'd1;
   localparam logic [2:0] OP_SECTOR_ERASE = 3'd2;
   localparam logic [2:0] OP_CHIP_ERASE   = 3'd3;
   localparam logic [2:0] OP_RESET_CMD    = 3'd4;

   // JEDEC command bytes
   localparam logic [7:0] CMD_AA = 8'hAA;
   localparam logic [7:0] CMD_55 = 8'h55;
   localparam logic [7:0] CMD_80 = 8'h80;
   localparam logic [7:0] CMD_A0 = 8'hA0;
   localparam logic [7:0] CMD_30 = 8'h30;
   localparam logic [7:0] CMD_10 = 8'h10;
   localparam logic [7:0] CMD_F0 = 8'hF0;

   // Unlock addresses
   localparam logic [11:0] ADDR_555 = 12'h555;
   localparam logic [11:0] ADDR_2AA = 12'h2AA;

   typedef enum logic [3:0] {
      IDLE, W_SETUP, W_STROBE, W_HOLD, R_ASSERT, R_CAPTURE, R_RECOVER, POLL_CHECK, FINISH
   } state_e;

   typedef enum logic [1:0] {AS_555, AS_2AA, AS_USER, AS_ZERO} addr_sel_e;

   typedef enum logic [2:0] {DS_AA, DS_55, DS_80, DS_A0, DS_30, DS_10, DS_F0, DS_WR} data_sel_e;

   // Command byte for a fixed data select; DS_WR is substituted with program data by the caller
   function automatic logic [7:0] cmd_byte(input data_sel_e sel);
      case (sel)
         DS_AA:   return CMD_AA;
         DS_55:   return CMD_55;
         DS_80:   return CMD_80;
         DS_A0:   return CMD_A0;
         DS_30:   return CMD_30;
         DS_10:   return CMD_10;
         DS_F0:   return CMD_F0;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/flash_seq_rom.sv
// rtl/flash_seq_rom.sv - step table mapping (op, step) to bus-write address/data selects
module flash_seq_rom
   import flash_pkg::*;
(
   input  logic [2:0] op_i,
   input  logic [2:0] step_i,
   output addr_sel_e  addr_sel_o,
   output data_sel_e  data_sel_o,
   output logic       last_o,
   output logic       poll_o
);

   // Unlock prefix is shared; the final step carries the op-specific byte
   always_comb begin
      addr_sel_o = AS_ZERO;
      data_sel_o = DS_F0;
      last_o     = 1'b1;
      poll_o     = 1'b0;
      case (op_i)
         OP_PROGRAM: begin
            last_o = 1'b0;
            case (step_i)
               3'd0:    begin addr_sel_o = AS_555;  data_sel_o = DS_AA; end
               3'd1:    begin addr_sel_o = AS_2AA;  data_sel_o = DS_55; end
               3'd2:    begin addr_sel_o = AS_555;  data_sel_o = DS_A0; end
               default: begin addr_sel_o = AS_USER; data_sel_o = DS_WR; last_o = 1'b1; poll_o = 1'b1; end
            endcase
         end
         OP_SECTOR_ERASE, OP_CHIP_ERASE: begin
            last_o = 1'b0;
            case (step_i)
               3'd0:    begin addr_sel_o = AS_555; data_sel_o = DS_AA; end
               3'd1:    begin addr_sel_o = AS_2AA; data_sel_o = DS_55; end
               3'd2:    begin addr_sel_o = AS_555; data_sel_o = DS_80; end
               3'd3:    begin addr_sel_o = AS_555; data_sel_o = DS_AA; end
               3'd4:    begin addr_sel_o = AS_2AA; data_sel_o = DS_55; end
               default: begin
                  last_o = 1'b1;
                  poll_o = 1'b1;
                  if (op_i == OP_SECTOR_ERASE) begin
                     addr_sel_o = AS_USER; data_sel_o = DS_30;
                  end else begin
                     addr_sel_o = AS_555;  data_sel_o = DS_10;
                  end
               end
            endcase
         end
         default: begin
            addr_sel_o = AS_ZERO;
            data_sel_o = DS_F0;
         end
      endcase
   end

endmodule

// File: rtl/flash_bus_sequencer.sv
// rtl/flash_bus_sequencer.sv - expands flash operations into JEDEC bus cycles with DQ7 polling
module flash_bus_sequencer
   import flash_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 16,
   parameter int WE_PULSE = 2,
   parameter int RD_WAIT  = 2,
   parameter int POLL_MAX = 1024
) (
   input  logic              SCL,
   input  logic              Reset,
   input  logic              Start,
   input  logic [2:0]        Op,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WrData,
   output logic [DATA_W-1:0] RdData,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [ADDR_W-1:0] FlashAddr,
   output logic              WE_n,
   output logic              OE_n,
   inout  wire  [DATA_W-1:0] IO
);

   localparam int CNT_MAX = (WE_PULSE > RD_WAIT) ? WE_PULSE : RD_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PCNT_W  = $clog2(POLL_MAX + 1);

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [2:0]          step_q, step_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q;

   addr_sel_e           rom_addr_sel;
   data_sel_e           rom_data_sel;
   logic                rom_last, rom_poll;
   logic                wr_phase, rd_phase, exp_dq7;
   logic [DATA_W-1:0]   wr_byte;

   flash_seq_rom u_rom (
      .op_i      (op_q),
      .step_i    (step_q),
      .addr_sel_o(rom_addr_sel),
      .data_sel_o(rom_data_sel),
      .last_o    (rom_last),
      .poll_o    (rom_poll)
   );

   // Program polls for the written DQ7; erase completes when DQ7 reads 1
   assign exp_dq7 = (op_q == OP_PROGRAM) ? wdata_q[7] : 1'b1;

   // State and latched-request registers
   always_ff @(posedge SCL or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         op_q       <= '0;
         step_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         poll_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         step_q     <= step_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         poll_cnt_q <= poll_cnt_d;
         err_q      <= err_d;
      end
   end

   // Read data is captured on the edge that ends the last OE_n-low cycle
   always_ff @(posedge SCL or posedge Reset) begin
      if (Reset)                                 rdata_q <= '0;
      else if (state_q == R_ASSERT && cnt_q == '0) rdata_q <= IO;
   end

   // Next-state logic: write steps, read cycles and the poll loop
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      step_d     = step_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      poll_cnt_d = poll_cnt_q;
      err_d      = err_q;
      case (state_q)
         IDLE: if (Start) begin
            op_d       = Op;
            addr_d     = Addr;
            wdata_d    = WrData;
            step_d     = '0;
            poll_cnt_d = '0;
            err_d      = 1'b0;
            if (Op == OP_READ) begin
               state_d = R_ASSERT;
               cnt_d   = CNT_W'(RD_WAIT - 1);
            end else if (Op > OP_RESET_CMD) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end else begin
               state_d = W_SETUP;
            end
         end
         W_SETUP: begin
            state_d = W_STROBE;
            cnt_d   = CNT_W'(WE_PULSE - 1);
         end
         W_STROBE: if (cnt_q == '0) state_d = W_HOLD;
                   else cnt_d = cnt_q - CNT_W'(1);
         W_HOLD: begin
            if (!rom_last) begin
               step_d  = step_q + 3'd1;
               state_d = W_SETUP;
            end else if (rom_poll) begin
               state_d = POLL_CHECK;
            end else begin
               state_d = FINISH;
            end
         end
         R_ASSERT: if (cnt_q == '0) state_d = R_CAPTURE;
                   else cnt_d = cnt_q - CNT_W'(1);
         R_CAPTURE: state_d = R_RECOVER;
         R_RECOVER: state_d = (op_q == OP_READ) ? FINISH : POLL_CHECK;
         POLL_CHECK: begin
            // poll_cnt_q == 0 means no read has been issued yet for this poll loop
            if (poll_cnt_q != '0 && rdata_q[7] == exp_dq7) begin
               state_d = FINISH;
            end else if (poll_cnt_q == PCNT_W'(POLL_MAX)) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end else begin
               poll_cnt_d = poll_cnt_q + PCNT_W'(1);
               cnt_d      = CNT_W'(RD_WAIT - 1);
               state_d    = R_ASSERT;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus pin decode from the current state and step table
   always_comb begin
      wr_phase = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);
      rd_phase = (state_q == R_ASSERT) || (state_q == R_CAPTURE) || (state_q == R_RECOVER);
      wr_byte  = (rom_data_sel == DS_WR) ? wdata_q : DATA_W'(cmd_byte(rom_data_sel));
      FlashAddr = '0;
      if (wr_phase) begin
         case (rom_addr_sel)
            AS_555:  FlashAddr = ADDR_W'(ADDR_555);
            AS_2AA:  FlashAddr = ADDR_W'(ADDR_2AA);
            AS_USER: FlashAddr = addr_q;
            default: FlashAddr = '0;
         endcase
      end else if (rd_phase) begin
         FlashAddr = addr_q;
      end
   end

   assign IO     = wr_phase ? wr_byte : {DATA_W{1'bz}};
   assign WE_n   = (state_q != W_STROBE);
   assign OE_n   = (state_q != R_ASSERT);
   assign Busy   = (state_q != IDLE);
   assign Done   = (state_q == FINISH);
   assign Error  = (state_q == FINISH) && err_q;
   assign RdData = rdata_q;

endmodule

// File: tb/tb_flash_bus_sequencer.sv
// tb/tb_flash_bus_sequencer.sv - directed table-driven bench with a DQ7-polling flash model
module tb_flash_bus_sequencer;

   localparam int DATA_W = 8, ADDR_W = 16, WE_PULSE = 2, RD_WAIT = 2, POLL_MAX = 8;

   logic              SCL = 1'b0, Reset = 1'b1, Start = 1'b0;
   logic [2:0]        Op = '0;
   logic [ADDR_W-1:0] Addr = '0;
   logic [DATA_W-1:0] WrData = '0;
   logic [DATA_W-1:0] RdData;
   logic              Busy, Done, Error, WE_n, OE_n;
   logic [ADDR_W-1:0] FlashAddr;
   wire  [DATA_W-1:0] io_bus;

   flash_bus_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WE_PULSE(WE_PULSE), .RD_WAIT(RD_WAIT), .POLL_MAX(POLL_MAX)
   ) dut (
      .SCL(SCL), .Reset(Reset), .Start(Start), .Op(Op), .Addr(Addr), .WrData(WrData),
      .RdData(RdData), .Busy(Busy), .Done(Done), .Error(Error), .FlashAddr(FlashAddr),
      .WE_n(WE_n), .OE_n(OE_n), .IO(io_bus)
   );

   always #5 SCL = ~SCL;

   // Flash model: reports busy (inverted DQ7) for mdl_busy reads, then the done value
   int                mdl_busy = 0;
   logic [DATA_W-1:0] mdl_done = '0;
   int                read_cnt = 0;
   assign io_bus = !OE_n ? ((read_cnt > mdl_busy) ? mdl_done : (mdl_done ^ 8'h80)) : {DATA_W{1'bz}};

   // Bus monitor
   logic [ADDR_W-1:0] wa [16];
   logic [DATA_W-1:0] wd [16];
   int   n_wr = 0, we_low = 0, oe_low = 0, bad_addr = 0, done_cnt = 0;
   logic we_prev = 1'b1, oe_prev = 1'b1;
   logic [ADDR_W-1:0] cur_addr = '0;

   always @(posedge SCL) begin
      if (!WE_n && we_prev) begin
         if (n_wr < 16) begin wa[n_wr] = FlashAddr; wd[n_wr] = io_bus; end
         n_wr++;
      end
      if (!WE_n) we_low++;
      if (!OE_n) begin
         oe_low++;
         if (oe_prev) begin
            read_cnt++;
            if (FlashAddr != cur_addr) bad_addr++;
         end
      end
      if (Done) done_cnt++;
      we_prev = WE_n;
      oe_prev = OE_n;
   end

   int passed = 0, total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic clear_mon();
      n_wr = 0; we_low = 0; oe_low = 0; bad_addr = 0; read_cnt = 0; done_cnt = 0;
   endtask

   task automatic tick();
      @(posedge SCL); #1;
   endtask

   typedef struct {
      logic [2:0]             op;
      logic [15:0]            addr;
      logic [7:0]             wdata;
      int                     busy;
      logic [7:0]             done_val;
      int                     n_wr;
      logic [5:0][15:0]       wa;
      logic [5:0][7:0]        wd;
      int                     n_rd;
      logic                   err;
      logic [7:0]             rdata;
      int                     lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // {op, addr, wdata, busy, done_val, n_wr, writes (step0 in [0]), n_rd, err, rdata, lat}
      vecs[0] = '{3'd0, 16'h1234, 8'h00, 0, 8'h5A, 0, '0, '0, 1, 1'b0, 8'h5A, 6};
      vecs[1] = '{3'd1, 16'h0100, 8'hC3, 3, 8'h80, 4,
                  {16'h0, 16'h0, 16'h0100, 16'h555, 16'h2AA, 16'h555},
                  {8'h0, 8'h0, 8'hC3, 8'hA0, 8'h55, 8'hAA}, 4, 1'b0, 8'h80, 39};
      vecs[2] = '{3'd2, 16'h2000, 8'h00, 1000, 8'h80, 6,
                  {16'h2000, 16'h2AA, 16'h555, 16'h555, 16'h2AA, 16'h555},
                  {8'h30, 8'h55, 8'hAA, 8'h80, 8'h55, 8'hAA}, 8, 1'b1, 8'h00, 67};
      vecs[3] = '{3'd3, 16'h3000, 8'h00, 0, 8'h80, 6,
                  {16'h555, 16'h2AA, 16'h555, 16'h555, 16'h2AA, 16'h555},
                  {8'h10, 8'h55, 8'hAA, 8'h80, 8'h55, 8'hAA}, 1, 1'b0, 8'h80, 32};
      vecs[4] = '{3'd4, 16'hBEEF, 8'h00, 0, 8'h00, 1,
                  {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000},
                  {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'hF0}, 0, 1'b0, 8'h80, 6};
      vecs[5] = '{3'd6, 16'h4444, 8'h11, 0, 8'h00, 0, '0, '0, 0, 1'b0, 8'h80, 2};
      vecs[6] = '{3'd1, 16'h0ABC, 8'h35, 1, 8'h00, 4,
                  {16'h0, 16'h0, 16'h0ABC, 16'h555, 16'h2AA, 16'h555},
                  {8'h0, 8'h0, 8'h35, 8'hA0, 8'h55, 8'hAA}, 2, 1'b0, 8'h00, 29};
      vecs[7] = '{3'd7, 16'h0000, 8'h00, 0, 8'h00, 0, '0, '0, 0, 1'b1, 8'h00, 2};
      vecs[8] = '{3'd0, 16'hFFFF, 8'h00, 0, 8'hA5, 0, '0, '0, 1, 1'b0, 8'hA5, 6};
      // Illegal ops flag Error
      vecs[5].err = 1'b1;

      // Reset state
      #1;
      chk("rst_busy", Busy, 0);  chk("rst_done", Done, 0); chk("rst_err", Error, 0);
      chk("rst_rdata", RdData, 0); chk("rst_faddr", FlashAddr, 0);
      chk("rst_we", WE_n, 1);    chk("rst_oe", OE_n, 1);
      tick(); tick();
      Reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         int   k;
         logic seen, err_at, busy_after;
         logic [7:0] rd_at;
         clear_mon();
         mdl_busy = vecs[i].busy; mdl_done = vecs[i].done_val; cur_addr = vecs[i].addr;
         Op = vecs[i].op; Addr = vecs[i].addr; WrData = vecs[i].wdata; Start = 1'b1;
         tick();
         Start = 1'b0;
         chk($sformatf("v%0d_busy_start", i), Busy, 1);
         k = 1; seen = Done; err_at = Error; rd_at = RdData;
         while (!seen && k < 500) begin
            tick(); k++;
            seen = Done; err_at = Error; rd_at = RdData;
         end
         chk($sformatf("v%0d_done_seen", i), seen, 1);
         chk($sformatf("v%0d_latency", i), k + 1, vecs[i].lat);
         chk($sformatf("v%0d_error", i), err_at, vecs[i].err);
         if (vecs[i].op == 3'd0) chk($sformatf("v%0d_rdata", i), rd_at, vecs[i].rdata);
         tick();
         busy_after = Busy;
         chk($sformatf("v%0d_idle_after", i), {busy_after, Done}, 2'b00);
         chk($sformatf("v%0d_nwr", i), n_wr, vecs[i].n_wr);
         chk($sformatf("v%0d_we_cycles", i), we_low, vecs[i].n_wr * WE_PULSE);
         chk($sformatf("v%0d_nrd", i), read_cnt, vecs[i].n_rd);
         chk($sformatf("v%0d_oe_cycles", i), oe_low, vecs[i].n_rd * RD_WAIT);
         chk($sformatf("v%0d_rd_addr", i), bad_addr, 0);
         for (int j = 0; j < vecs[i].n_wr && j < 6; j++) begin
            chk($sformatf("v%0d_wa%0d", i, j), wa[j], vecs[i].wa[j]);
            chk($sformatf("v%0d_wd%0d", i, j), wd[j], vecs[i].wd[j]);
         end
      end

      // Start pulsed during a busy chip erase is dropped
      begin
         int k;
         clear_mon();
         mdl_busy = 2; mdl_done = 8'h80; cur_addr = 16'h0000;
         Op = 3'd3; Addr = 16'h0000; Start = 1'b1;
         tick(); Start = 1'b0;
         for (int c = 0; c < 5; c++) tick();
         Op = 3'd0; Addr = 16'h1111; Start = 1'b1;
         tick(); Start = 1'b0;
         k = 0;
         while (Busy && k < 300) begin tick(); k++; end
         for (int c = 0; c < 10; c++) tick();
         chk("drop_done_count", done_cnt, 1);
         chk("drop_reads", read_cnt, 3);
         chk("drop_writes", n_wr, 6);
         chk("drop_idle", Busy, 0);
      end

      // Reset during W_STROBE of a program aborts at once with no Done
      begin
         int k;
         clear_mon();
         mdl_busy = 0; mdl_done = 8'h80;
         Op = 3'd1; Addr = 16'h0100; WrData = 8'hC3; Start = 1'b1;
         tick(); Start = 1'b0;
         k = 0;
         while (WE_n && k < 50) begin tick(); k++; end
         chk("mid_we_low", WE_n, 0);
         #2 Reset = 1'b1;
         #1;
         chk("mid_rst_we", WE_n, 1);
         chk("mid_rst_busy", Busy, 0);
         chk("mid_rst_faddr", FlashAddr, 0);
         chk("mid_rst_rdata", RdData, 0);
         tick();
         Reset = 1'b0;
         for (int c = 0; c < 20; c++) tick();
         chk("mid_no_done", done_cnt, 0);
         chk("mid_still_idle", Busy, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
